// File: rtl/ahb_apb_pkg.sv
// Shared constants for the AHB-to-APB bridge: AHB transfer/response codes,
// default peripheral map and the AHB-side error-response state encoding.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_SLV_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SIZE = 32'h0400_0000;

  // Largest supported transfer is a 32-bit word.
  localparam logic [2:0] MAX_HSIZE = 3'b010;

  localparam logic [1:0] ERR_IDLE = 2'd0;
  localparam logic [1:0] ERR_1    = 2'd1;
  localparam logic [1:0] ERR_2    = 2'd2;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational peripheral decoder: peripheral n owns the window
// [SLV_BASE + n*SLV_SIZE, SLV_BASE + (n+1)*SLV_SIZE).
module ahb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_SLV  = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE = ADDR_W'(ahb_apb_pkg::DEF_SLV_BASE),
  parameter logic [ADDR_W-1:0] SLV_SIZE = ADDR_W'(ahb_apb_pkg::DEF_SLV_SIZE)
) (
  input  logic [ADDR_W-1:0]  Haddr,
  output logic [NUM_SLV-1:0] tempselx,
  output logic               in_range
);

  // Window limits can run past 2^ADDR_W, so compare in a widened domain.
  localparam int EW = ADDR_W + $clog2(NUM_SLV + 1) + 1;

  logic [EW-1:0] addr_ext;

  assign addr_ext = {{(EW - ADDR_W){1'b0}}, Haddr};

  for (genvar n = 0; n < NUM_SLV; n++) begin : g_win
    localparam logic [EW-1:0] LO = EW'(SLV_BASE) + EW'(n) * EW'(SLV_SIZE);
    localparam logic [EW-1:0] HI = LO + EW'(SLV_SIZE);
    assign tempselx[n] = (addr_ext >= LO) && (addr_ext < HI);
  end

  assign in_range = |tempselx;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: qualifies transfers, pipelines
// address/data/direction for the APB FSM and issues the two-cycle ERROR reply.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SLV_BASE = ADDR_W'(ahb_apb_pkg::DEF_SLV_BASE),
  parameter logic [ADDR_W-1:0] SLV_SIZE = ADDR_W'(ahb_apb_pkg::DEF_SLV_SIZE),
  parameter int                NUM_SLV  = 3
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  input  logic [1:0]         Htrans,
  input  logic [2:0]         Hsize,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  input  logic [DATA_W-1:0]  Prdata,
  input  logic               fsm_hreadyout,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [ADDR_W-1:0]  Haddr1,
  output logic [ADDR_W-1:0]  Haddr2,
  output logic [DATA_W-1:0]  Hwdata1,
  output logic [DATA_W-1:0]  Hwdata2,
  output logic               Hwritereg,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata
);

  logic              in_range;
  logic              active;
  logic              illegal;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] haddr1_q, haddr2_q;
  logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
  logic              hwrite_q;

  ahb_addr_decoder #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV),
    .SLV_BASE(SLV_BASE),
    .SLV_SIZE(SLV_SIZE)
  ) u_decoder (
    .Haddr   (Haddr),
    .tempselx(tempselx),
    .in_range(in_range)
  );

  assign active  = htrans_active(Htrans);
  assign illegal = active && (!in_range || (Hsize > MAX_HSIZE));

  // ERR_1 holds the master off, so nothing presented then may reach the APB FSM.
  assign valid = Hreadyin && active && !illegal && (state_q != ERR_1);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ERR_IDLE: if (Hreadyin && illegal) state_d = ERR_1;
      ERR_1:    state_d = ERR_2;
      ERR_2:    state_d = (Hreadyin && illegal) ? ERR_1 : ERR_IDLE;
      default:  state_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= ERR_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Illegal transfers are captured too; valid=0 tells the APB FSM to ignore them.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else if (Hreadyin) begin
      haddr1_q  <= Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= Hwrite;
    end
  end

  always_comb begin
    Hresp     = HRESP_OKAY;
    Hreadyout = fsm_hreadyout;
    case (state_q)
      ERR_1: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b0;
      end
      ERR_2: begin
        Hresp     = HRESP_ERROR;
        Hreadyout = 1'b1;
      end
      default: ;
    endcase
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: decode table, directed multi-cycle
// sequences and random traffic compared against a transaction-level model.
module tb_ahb_slave_if;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0400_0000;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        fsm_hreadyout;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
  logic        Hwritereg;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  int errors = 0;
  int checks = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize),
    .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata),
    .Prdata(Prdata), .fsm_hreadyout(fsm_hreadyout), .valid(valid),
    .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of sampled address phases (newest first) and the number of
  // ERROR-response beats still owed to the master (2 = first beat next).
  logic [31:0] hist_addr[$];
  logic [31:0] hist_wdata[$];
  logic        hist_write[$];
  int          err_beats_left;

  function automatic logic [2:0] m_sel(input logic [31:0] a);
    longint unsigned off;
    logic [2:0] r;
    r = '0;
    if (a >= BASE) begin
      off = longint'(a) - longint'(BASE);
      if (off < 3 * longint'(SIZE)) r[int'(off / longint'(SIZE))] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic m_active(input logic [1:0] tr);
    return tr[1];
  endfunction

  function automatic logic m_illegal(input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a);
    return m_active(tr) && ((m_sel(a) == 3'b000) || (sz > 3'd2));
  endfunction

  task automatic model_reset();
    hist_addr.delete();
    hist_wdata.delete();
    hist_write.delete();
    err_beats_left = 0;
  endtask

  task automatic model_step();
    if (err_beats_left == 2) err_beats_left = 1;
    else if (Hreadyin && m_illegal(Htrans, Hsize, Haddr)) err_beats_left = 2;
    else err_beats_left = 0;
    if (Hreadyin) begin
      hist_addr.push_front(Haddr);
      hist_wdata.push_front(Hwdata);
      hist_write.push_front(Hwrite);
      if (hist_addr.size() > 2) begin
        void'(hist_addr.pop_back());
        void'(hist_wdata.pop_back());
      end
      if (hist_write.size() > 1) void'(hist_write.pop_back());
    end
  endtask

  task automatic compare_all();
    logic exp_valid, exp_rdy;
    exp_valid = Hreadyin && m_active(Htrans) && !m_illegal(Htrans, Hsize, Haddr)
                && (err_beats_left != 2);
    exp_rdy   = (err_beats_left == 2) ? 1'b0 : (err_beats_left == 1) ? 1'b1 : fsm_hreadyout;
    check("valid", 64'(valid), 64'(exp_valid));
    check("tempselx", 64'(tempselx), 64'(m_sel(Haddr)));
    check("Hrdata", 64'(Hrdata), 64'(Prdata));
    check("Hresp", 64'(Hresp), (err_beats_left != 0) ? 64'd1 : 64'd0);
    check("Hreadyout", 64'(Hreadyout), 64'(exp_rdy));
    check("Haddr1", 64'(Haddr1), (hist_addr.size() > 0) ? 64'(hist_addr[0]) : 64'd0);
    check("Haddr2", 64'(Haddr2), (hist_addr.size() > 1) ? 64'(hist_addr[1]) : 64'd0);
    check("Hwdata1", 64'(Hwdata1), (hist_wdata.size() > 0) ? 64'(hist_wdata[0]) : 64'd0);
    check("Hwdata2", 64'(Hwdata2), (hist_wdata.size() > 1) ? 64'(hist_wdata[1]) : 64'd0);
    check("Hwritereg", 64'(Hwritereg), (hist_write.size() > 0) ? 64'(hist_write[0]) : 64'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic [1:0] tr, input logic [2:0] sz, input logic wr,
                       input logic rdy, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] prd, input logic fr);
    Htrans = tr; Hsize = sz; Hwrite = wr; Hreadyin = rdy;
    Haddr = a; Hwdata = wd; Prdata = prd; fsm_hreadyout = fr;
    @(negedge Hclk);
  endtask

  task automatic tick();
    @(posedge Hclk);
    model_step();
    #1;
  endtask

  task automatic idle_cycle();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    compare_all();
    tick();
  endtask

  typedef struct {
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic        rdy;
    logic [31:0] addr;
    logic        exp_valid;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b10, 3'b010, 1'b1, 32'h8000_0000, 1'b1, 3'b001};
    vecs[1]  = '{2'b11, 3'b000, 1'b1, 32'h83FF_FFFF, 1'b1, 3'b001};
    vecs[2]  = '{2'b10, 3'b001, 1'b1, 32'h8400_0000, 1'b1, 3'b010};
    vecs[3]  = '{2'b11, 3'b010, 1'b1, 32'h87FF_FFFC, 1'b1, 3'b010};
    vecs[4]  = '{2'b10, 3'b010, 1'b1, 32'h8800_0000, 1'b1, 3'b100};
    vecs[5]  = '{2'b10, 3'b010, 1'b1, 32'h8BFF_FFFF, 1'b1, 3'b100};
    vecs[6]  = '{2'b10, 3'b010, 1'b1, 32'h8C00_0000, 1'b0, 3'b000};
    vecs[7]  = '{2'b10, 3'b010, 1'b1, 32'h7FFF_FFFF, 1'b0, 3'b000};
    vecs[8]  = '{2'b10, 3'b011, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
    vecs[9]  = '{2'b00, 3'b010, 1'b1, 32'h8000_0000, 1'b0, 3'b001};
    vecs[10] = '{2'b01, 3'b010, 1'b1, 32'h8400_0000, 1'b0, 3'b010};
    vecs[11] = '{2'b10, 3'b010, 1'b0, 32'h8800_0000, 1'b0, 3'b100};

    // Reset: outputs must be in their idle values while Hresetn is low.
    Hresetn = 1'b0;
    Htrans = 2'b00; Hsize = 3'b010; Hwrite = 1'b0; Hreadyin = 1'b1;
    Haddr = '0; Hwdata = '0; Prdata = '0; fsm_hreadyout = 1'b1;
    model_reset();
    #2;
    check("rst_Hresp", 64'(Hresp), 64'd0);
    check("rst_Hreadyout", 64'(Hreadyout), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_Haddr1", 64'(Haddr1), 64'd0);
    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();

    // Test 1: write to peripheral 0 then its data phase.
    apply(2'b10, 3'b010, 1'b1, 1'b1, 32'h8000_000A, 32'h0, 32'h0, 1'b1);
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_sel", 64'(tempselx), 64'd1);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'hAAAA_BBBB, 32'h0, 1'b1);
    check("t1_Haddr1", 64'(Haddr1), 64'h8000_000A);
    check("t1_Hwritereg", 64'(Hwritereg), 64'd1);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t1_Hwdata1", 64'(Hwdata1), 64'hAAAA_BBBB);
    check("t1_Haddr2", 64'(Haddr2), 64'h8000_000A);
    compare_all();
    tick();

    // Test 2: read from peripheral 2 with passthrough read data.
    apply(2'b10, 3'b010, 1'b0, 1'b1, 32'h8800_0004, 32'h0, 32'h1234_5678, 1'b1);
    check("t2_sel", 64'(tempselx), 64'd4);
    check("t2_valid", 64'(valid), 64'd1);
    check("t2_Hrdata", 64'(Hrdata), 64'h1234_5678);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t2_Hwritereg", 64'(Hwritereg), 64'd0);
    check("t2_Haddr1", 64'(Haddr1), 64'h8800_0004);
    compare_all();
    tick();

    // Test 3: unmapped address produces a two-cycle ERROR response.
    apply(2'b10, 3'b010, 1'b0, 1'b1, 32'h9000_0000, 32'h0, 32'h0, 1'b1);
    check("t3_valid", 64'(valid), 64'd0);
    check("t3_sel", 64'(tempselx), 64'd0);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t3_e1_Hresp", 64'(Hresp), 64'd1);
    check("t3_e1_Hreadyout", 64'(Hreadyout), 64'd0);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t3_e2_Hresp", 64'(Hresp), 64'd1);
    check("t3_e2_Hreadyout", 64'(Hreadyout), 64'd1);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t3_done_Hresp", 64'(Hresp), 64'd0);
    compare_all();
    tick();

    // Test 4: oversize transfer, then another illegal one during the second beat.
    apply(2'b10, 3'b011, 1'b1, 1'b1, 32'h8400_0000, 32'h0, 32'h0, 1'b1);
    check("t4_c0_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b10, 3'b010, 1'b1, 1'b0, 32'h8400_0000, 32'h0, 32'h0, 1'b1);
    check("t4_c1_resp", 64'({Hresp, Hreadyout}), 64'b010);
    check("t4_c1_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b10, 3'b011, 1'b1, 1'b1, 32'h8400_0000, 32'h0, 32'h0, 1'b1);
    check("t4_c2_resp", 64'({Hresp, Hreadyout}), 64'b011);
    check("t4_c2_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b10, 3'b010, 1'b1, 1'b1, 32'h8400_0000, 32'h0, 32'h0, 1'b1);
    check("t4_c3_resp", 64'({Hresp, Hreadyout}), 64'b010);
    check("t4_c3_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t4_c4_resp", 64'({Hresp, Hreadyout}), 64'b011);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t4_c5_resp", 64'({Hresp, Hreadyout}), 64'b001);
    compare_all();
    tick();

    // Test 5: stall holds the pipeline; IDLE/BUSY never raise errors.
    apply(2'b10, 3'b010, 1'b1, 1'b1, 32'h8400_0010, 32'h5555_0000, 32'h0, 1'b1);
    compare_all();
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(2'b10, 3'b010, 1'b0, 1'b0, 32'h9000_0000 + 32'(i), 32'hDEAD_0000 + 32'(i), 32'h0, 1'b0);
      check("t5_stall_Haddr1", 64'(Haddr1), 64'h8400_0010);
      check("t5_stall_Hwdata1", 64'(Hwdata1), 64'h5555_0000);
      check("t5_stall_Hreadyout", 64'(Hreadyout), 64'd0);
      compare_all();
      tick();
    end
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 1'b1);
    check("t5_nostall_err", 64'(Hresp), 64'd0);
    check("t5_idle_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b01, 3'b010, 1'b0, 1'b1, 32'h8400_0000, 32'h0, 32'h0, 1'b1);
    check("t5_busy_valid", 64'(valid), 64'd0);
    compare_all();
    tick();
    apply(2'b00, 3'b010, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    check("t5_busy_noerr", 64'(Hresp), 64'd0);
    compare_all();
    tick();

    // Decode/valid table.
    foreach (vecs[k]) begin
      apply(vecs[k].tr, vecs[k].sz, 1'b0, vecs[k].rdy, vecs[k].addr, 32'(k), 32'h0, 1'b1);
      check($sformatf("vec%0d_valid", k), 64'(valid), 64'(vecs[k].exp_valid));
      check($sformatf("vec%0d_sel", k), 64'(tempselx), 64'(vecs[k].exp_sel));
      compare_all();
      tick();
      idle_cycle();
      idle_cycle();
    end

    // Test 6: asynchronous reset while in the first error beat.
    apply(2'b10, 3'b010, 1'b1, 1'b1, 32'hA000_0000, 32'h7777_7777, 32'h0, 1'b1);
    compare_all();
    tick();
    Hreadyin = 1'b0;
    check("t6_pre_Hreadyout", 64'(Hreadyout), 64'd0);
    Hresetn = 1'b0;
    #1;
    model_reset();
    check("t6_Hreadyout", 64'(Hreadyout), 64'd1);
    check("t6_Hresp", 64'(Hresp), 64'd0);
    check("t6_pipe", 64'({Haddr1 | Haddr2 | Hwdata1 | Hwdata2, Hwritereg}), 64'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + SIZE * $urandom_range(0, 2) + ($urandom & (SIZE - 1));
        3:       a = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF);
        4: begin
          case ($urandom_range(0, 3))
            0: a = 32'h7FFF_FFFF;
            1: a = 32'h8BFF_FFFF;
            2: a = 32'h8C00_0000;
            default: a = 32'h87FF_FFFF;
          endcase
        end
        default: a = $urandom;
      endcase
      sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      apply(2'($urandom), sz, 1'($urandom), ($urandom_range(0, 4) != 0), a,
            $urandom, $urandom, 1'($urandom));
      compare_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
